crash_renderer: RTL and testbench
=================================

Name: crash_renderer

Overview:
- Pixel-generation stage directly downstream of the VGA timing generator; consumes its hc/vc counters and drives the 12-bit RGB to the DAC pins.
- Holds the Color Crasher game state: a player paddle steered by two buttons, and a falling coloured block respawned at an LFSR-chosen position and colour.
- Detects paddle/block collisions and keeps a score.
- All game state updates once per frame; pixel output is registered.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- PLAYER_W, 32, paddle width (px)
- PLAYER_H, 16, paddle height (px)
- PLAYER_Y, 448, paddle top row (fixed)
- BLOCK_SIZE, 24, block edge length (px)
- PLAYER_STEP, 4, paddle move per frame (px)
- FALL_STEP, 2, block fall per frame (px)
- FLASH_FRAMES, 30, frames the paddle flashes after a hit
- LFSR_SEED, 16'hACE1, LFSR reset value, must be nonzero

Ports:
- vgaclk  in  1  pixel clock
- rst  in  1  synchronous reset, active-low; clock vgaclk
- hc  in  10  horizontal counter from timing stage (0..799)
- vc  in  10  vertical counter from timing stage (0..524)
- btn_left  in  1  move-left request, already synchronised
- btn_right  in  1  move-right request, already synchronised
- red  out  4  pixel red
- green  out  4  pixel green
- blue  out  4  pixel blue
- hit  out  1  one-cycle pulse on collision
- score  out  8  saturating hit count

Behaviour:
- Reset (rst==0 at a vgaclk edge), taking effect the next cycle, including mid-frame:
  - rgb=0, hit=0, score=0
  - px=(H_ACTIVE-PLAYER_W)/2=304
  - by=0, bx=LFSR_SEED[8:0]=225, colour index=LFSR_SEED[14:12]=2
  - flash counter=0, lfsr=LFSR_SEED
- LFSR:
  - 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
  - Shifts every non-reset cycle (free-running).
- frame_tick: internal single-cycle strobe when hc==0 && vc==V_ACTIVE (start of vertical blanking). Game state changes only on frame_tick.
- Paddle, on tick:
  - left&&!right: px=max(px-PLAYER_STEP,0).
  - right&&!left: px=min(px+PLAYER_STEP, H_ACTIVE-PLAYER_W)=608 max.
  - Both or neither pressed: no move.
- Collision, evaluated on tick using pre-update positions:
  - Overlap condition: bx<px+PLAYER_W && px<bx+BLOCK_SIZE && by+BLOCK_SIZE>PLAYER_Y && by<PLAYER_Y+PLAYER_H.
  - On hit:
    - score+=1, saturating at 255.
    - hit=1 for exactly the cycle after tick.
    - flash counter loads FLASH_FRAMES.
    - hit colour index is latched.
    - Block respawns: by=0, bx=lfsr[8:0], colour index=lfsr[14:12].
  - Else if by+FALL_STEP>=V_ACTIVE: respawn the same way; score, hit and flash unchanged.
  - Else: by+=FALL_STEP.
  - Collision takes priority over miss in the same tick.
- Flash: on each tick with flash counter nonzero and no new hit, decrement by 1.
- Render, registered, latency 1 cycle:
  - RGB on cycle N+1 corresponds to hc/vc sampled on cycle N; the timing stage delays hsync/vsync by one cycle to match.
  - Active area is hc<H_ACTIVE && vc<V_ACTIVE.
  - Priority inside the active area:
    1. Block: palette[colour index] when bx<=hc<bx+BLOCK_SIZE and by<=vc<by+BLOCK_SIZE.
    2. Paddle: palette[latched hit index] while flash counter>0, else white F,F,F.
    3. Background: 0,0,3.
  - Outside the active area: rgb=0,0,0.
- Arithmetic: position compares use 11-bit widened sums so no wrap at the right/bottom edge; bx is at most 511, so the block is always fully on-screen.
- Palette, 3-bit index → rgb12: 0 F00, 1 0F0, 2 00F, 3 FF0, 4 F0F, 5 0FF, 6 F80, 7 8F0.

Decomposition:
- Package crash_pkg:
  - H_ACTIVE/V_ACTIVE constants
  - rgb12_t struct {r,g,b 4-bit}
  - palette constant array
  - colour index typedef (3-bit)
- Sub-module lfsr16: clk, rst, seed parameter, q[15:0].

Test Plan:
- Reset: hold rst=0 2 cycles mid-line → rgb=000, score=0, hit=0; next frame pixel (hc=304,vc=448) is FFF one cycle later, (hc=225,vc=0) is 00F.
- Clamp: btn_left held 80 frames → px=0 after frame 76; pixel (0,450)=FFF, (32,450)=003; px does not go negative. btn_right held → px stops at 608.
- Both buttons held 10 frames → px stays 304.
- Miss: no buttons → by advances 2/frame, tick 240 respawns block at by=0 with lfsr-derived bx/colour; score=0, hit never asserted.
- Hit: btn_left for first 14 frames (px=248), then release → tick 214 (by=426) gives score=1, one-cycle hit, by=0, paddle drawn 00F for 30 frames then FFF.
- Blanking/priority: (hc=700,vc=100) and (hc=100,vc=500) → rgb=000 always; block overlapping paddle pixel shows block colour.

Source files
------------

// File: rtl/crash_pkg.sv
// Shared definitions for the Color Crasher pixel stage.
// Holds the visible-area size, the 12-bit colour type, the colour index
// type and the eight-entry block palette.
package crash_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  typedef logic [2:0] cidx_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  localparam rgb12_t PALETTE [8] = '{
    rgb12_t'(12'hF00), rgb12_t'(12'h0F0), rgb12_t'(12'h00F), rgb12_t'(12'hFF0),
    rgb12_t'(12'hF0F), rgb12_t'(12'h0FF), rgb12_t'(12'hF80), rgb12_t'(12'h8F0)
  };

  localparam rgb12_t RGB_WHITE = rgb12_t'(12'hFFF);
  localparam rgb12_t RGB_BG    = rgb12_t'(12'h003);
  localparam rgb12_t RGB_OFF   = rgb12_t'(12'h000);

endpackage

// File: rtl/crash_renderer_if.sv
// Signal bundle between the VGA timing stage / button front end and the
// Color Crasher renderer.
//   hc, vc          : raster counters from the timing stage
//   btn_left/right  : synchronised move requests
//   red/green/blue  : registered pixel colour to the DAC pins
//   hit, score      : collision pulse and saturating hit count
// master = timing/button side, slave = renderer.
interface crash_renderer_if;
  logic [9:0] hc;
  logic [9:0] vc;
  logic       btn_left;
  logic       btn_right;
  logic [3:0] red;
  logic [3:0] green;
  logic [3:0] blue;
  logic       hit;
  logic [7:0] score;

  modport master (output hc, vc, btn_left, btn_right,
                  input  red, green, blue, hit, score);
  modport slave  (input  hc, vc, btn_left, btn_right,
                  output red, green, blue, hit, score);
endinterface

// File: rtl/crash_renderer_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1.
//   clk : clock
//   rst : synchronous active-low reset, loads SEED
//   q   : current register value
// Shifts right each cycle; the new MSB is the XOR of the tap bits.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);

  logic [15:0] q_q;
  logic [15:0] q_d;

  always_comb begin
    q_d = {q_q[0] ^ q_q[2] ^ q_q[3] ^ q_q[5], q_q[15:1]};
  end

  always_ff @(posedge clk) begin
    if (!rst) q_q <= SEED;
    else      q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/crash_renderer.sv
// Color Crasher pixel generator, one stage downstream of the VGA timing.
//   vgaclk : pixel clock
//   rst    : synchronous active-low reset
//   bus    : slave side of crash_renderer_if (hc/vc/buttons in,
//            rgb/hit/score out)
// Game state (paddle, falling block, score, flash) advances once per frame
// on the first cycle of vertical blanking; the pixel colour is registered,
// so rgb lags hc/vc by one cycle.
module crash_renderer
  import crash_pkg::*;
#(
  parameter int          PLAYER_W     = 32,
  parameter int          PLAYER_H     = 16,
  parameter int          PLAYER_Y     = 448,
  parameter int          BLOCK_SIZE   = 24,
  parameter int          PLAYER_STEP  = 4,
  parameter int          FALL_STEP    = 2,
  parameter int          FLASH_FRAMES = 30,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic             vgaclk,
  input  logic             rst,
  crash_renderer_if.slave  bus
);

  localparam logic [9:0]  PX_RESET = 10'((H_ACTIVE - PLAYER_W) / 2);
  localparam logic [9:0]  PX_MAX   = 10'(H_ACTIVE - PLAYER_W);

  // Positions are compared as 11-bit sums so x+size never wraps.
  function automatic logic [10:0] w11(input logic [9:0] x);
    return {1'b0, x};
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] x);
    return (x == 8'hFF) ? x : x + 8'd1;
  endfunction

  logic [15:0] lfsr;
  logic [3:0]  lfsr_unused;

  logic [9:0]  px_q, px_d;
  logic [9:0]  bx_q, bx_d;
  logic [9:0]  by_q, by_d;
  cidx_t       ci_q, ci_d;
  cidx_t       hit_ci_q, hit_ci_d;
  logic [7:0]  flash_q, flash_d;
  logic [7:0]  score_q, score_d;
  logic        hit_q, hit_d;
  rgb12_t      rgb_q, rgb_d;

  logic        frame_tick;
  logic        collide;
  logic        miss;
  logic        in_active;
  logic        in_block;
  logic        in_pad;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk (vgaclk),
    .rst (rst),
    .q   (lfsr)
  );

  // Only the position and colour fields of the LFSR are consumed.
  assign lfsr_unused = {lfsr[15], lfsr[11:9]};

  // ---- frame update: game state, evaluated on pre-update positions ----
  always_comb begin
    frame_tick = (bus.hc == 10'd0) && (bus.vc == 10'(V_ACTIVE));
    collide = (w11(bx_q) < w11(px_q) + 11'(PLAYER_W))
           && (w11(px_q) < w11(bx_q) + 11'(BLOCK_SIZE))
           && (w11(by_q) + 11'(BLOCK_SIZE) > 11'(PLAYER_Y))
           && (w11(by_q) < 11'(PLAYER_Y + PLAYER_H));
    miss = (w11(by_q) + 11'(FALL_STEP) >= 11'(V_ACTIVE));

    px_d     = px_q;
    bx_d     = bx_q;
    by_d     = by_q;
    ci_d     = ci_q;
    hit_ci_d = hit_ci_q;
    flash_d  = flash_q;
    score_d  = score_q;
    hit_d    = 1'b0;

    if (frame_tick) begin
      case ({bus.btn_left, bus.btn_right})
        2'b10:   px_d = (px_q >= 10'(PLAYER_STEP)) ? px_q - 10'(PLAYER_STEP) : 10'd0;
        2'b01:   px_d = (w11(px_q) + 11'(PLAYER_STEP) > w11(PX_MAX)) ? PX_MAX
                                                                    : px_q + 10'(PLAYER_STEP);
        default: px_d = px_q;
      endcase

      if (collide || miss) begin
        by_d = 10'd0;
        bx_d = {1'b0, lfsr[8:0]};
        ci_d = lfsr[14:12];
      end else begin
        by_d = by_q + 10'(FALL_STEP);
      end

      if (collide) begin
        hit_d    = 1'b1;
        score_d  = sat_inc(score_q);
        flash_d  = 8'(FLASH_FRAMES);
        hit_ci_d = ci_q;
      end else if (flash_q != 8'd0) begin
        flash_d = flash_q - 8'd1;
      end
    end
  end

  // ---- render: colour for the current hc/vc, registered below ----
  always_comb begin
    in_active = (w11(bus.hc) < 11'(H_ACTIVE)) && (w11(bus.vc) < 11'(V_ACTIVE));
    in_block  = (bus.hc >= bx_q) && (w11(bus.hc) < w11(bx_q) + 11'(BLOCK_SIZE))
             && (bus.vc >= by_q) && (w11(bus.vc) < w11(by_q) + 11'(BLOCK_SIZE));
    in_pad    = (bus.hc >= px_q) && (w11(bus.hc) < w11(px_q) + 11'(PLAYER_W))
             && (w11(bus.vc) >= 11'(PLAYER_Y))
             && (w11(bus.vc) < 11'(PLAYER_Y + PLAYER_H));

    rgb_d = RGB_OFF;
    if (in_active) begin
      if (in_block)    rgb_d = PALETTE[ci_q];
      else if (in_pad) rgb_d = (flash_q != 8'd0) ? PALETTE[hit_ci_q] : RGB_WHITE;
      else             rgb_d = RGB_BG;
    end
  end

  // ---- state and output registers ----
  always_ff @(posedge vgaclk) begin
    if (!rst) begin
      px_q     <= PX_RESET;
      bx_q     <= {1'b0, LFSR_SEED[8:0]};
      by_q     <= 10'd0;
      ci_q     <= LFSR_SEED[14:12];
      hit_ci_q <= LFSR_SEED[14:12];
      flash_q  <= 8'd0;
      score_q  <= 8'd0;
      hit_q    <= 1'b0;
      rgb_q    <= RGB_OFF;
    end else begin
      px_q     <= px_d;
      bx_q     <= bx_d;
      by_q     <= by_d;
      ci_q     <= ci_d;
      hit_ci_q <= hit_ci_d;
      flash_q  <= flash_d;
      score_q  <= score_d;
      hit_q    <= hit_d;
      rgb_q    <= rgb_d;
    end
  end

  assign bus.red   = rgb_q.r;
  assign bus.green = rgb_q.g;
  assign bus.blue  = rgb_q.b;
  assign bus.hit   = hit_q;
  assign bus.score = score_q;

endmodule

// File: tb/tb_crash_renderer.sv
// Scoreboard bench for crash_renderer. The driver steps hc/vc directly
// (one frame = one tick cycle plus a few probe pixels), pushes the expected
// {rgb, hit, score} per driven cycle, and a monitor compares one cycle later.
module tb_crash_renderer;

  bit   vgaclk = 1'b0;
  logic rst;
  always #5 vgaclk = ~vgaclk;

  crash_renderer_if bus();

  crash_renderer dut (
    .vgaclk (vgaclk),
    .rst    (rst),
    .bus    (bus)
  );

  typedef struct packed {
    logic [11:0] rgb;
    logic        hit;
    logic [7:0]  score;
    logic [9:0]  h;
    logic [9:0]  v;
    logic [7:0]  tag;
  } exp_t;

  localparam logic [7:0] T_MODEL = 8'd0, T_RESET = 8'd1, T_RSTPIX = 8'd2,
                         T_LEFT  = 8'd3, T_RIGHT = 8'd4, T_BOTH   = 8'd5,
                         T_BLANK = 8'd6, T_OVER  = 8'd7, T_HIT    = 8'd8,
                         T_MISS  = 8'd9;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   probe   = 1'b0;
  bit   probe_d = 1'b0;
  logic bl = 1'b0, br = 1'b0;

  // Reference game state
  int          m_px, m_bx, m_by, m_ci, m_hci, m_flash, m_score;
  logic [15:0] m_lfsr;

  always @(posedge vgaclk) begin
    if (!rst) m_lfsr <= 16'hACE1;
    else      m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
  end

  function automatic string tag_name(input logic [7:0] t);
    case (t)
      T_MODEL: return "model";
      T_RESET: return "reset";
      T_RSTPIX: return "reset_pixel";
      T_LEFT:  return "clamp_left";
      T_RIGHT: return "clamp_right";
      T_BOTH:  return "both_buttons";
      T_BLANK: return "blanking";
      T_OVER:  return "block_over_paddle";
      T_HIT:   return "hit_flash";
      T_MISS:  return "miss_respawn";
      default: return "unknown";
    endcase
  endfunction

  function automatic logic [11:0] pal(input int i);
    case (i)
      0: return 12'hF00;  1: return 12'h0F0;  2: return 12'h00F;  3: return 12'hFF0;
      4: return 12'hF0F;  5: return 12'h0FF;  6: return 12'hF80;  default: return 12'h8F0;
    endcase
  endfunction

  function automatic logic [11:0] model_rgb(input int h, input int v);
    if (!(h < 640 && v < 480)) return 12'h000;
    if (h >= m_bx && h < m_bx + 24 && v >= m_by && v < m_by + 24) return pal(m_ci);
    if (h >= m_px && h < m_px + 32 && v >= 448 && v < 464)
      return (m_flash > 0) ? pal(m_hci) : 12'hFFF;
    return 12'h003;
  endfunction

  task automatic model_tick(output bit col);
    col = (m_bx < m_px + 32) && (m_px < m_bx + 24) && (m_by + 24 > 448) && (m_by < 464);
    if (bl && !br)      m_px = (m_px - 4 < 0) ? 0 : m_px - 4;
    else if (br && !bl) m_px = (m_px + 4 > 608) ? 608 : m_px + 4;
    if (col || m_by + 2 >= 480) begin
      m_by = 0;
      m_bx = int'(m_lfsr[8:0]);
      m_ci = int'(m_lfsr[14:12]);
    end else begin
      m_by = m_by + 2;
    end
    if (col) begin
      m_score = (m_score == 255) ? 255 : m_score + 1;
      m_flash = 30;
      m_hci   = m_ci_prev_dummy(col);
    end else if (m_flash > 0) begin
      m_flash = m_flash - 1;
    end
  endtask

  // Colour index of the block that was struck, captured before respawn.
  int hit_ci_cap;
  function automatic int m_ci_prev_dummy(input bit c);
    return c ? hit_ci_cap : m_hci;
  endfunction

  // Drive one cycle; c_rgb/c_score of -1 take the value from the model.
  task automatic cyc(input int h, input int v, input logic [7:0] tag,
                     input int c_rgb, input int c_score);
    exp_t e;
    bit   hv;
    bus.hc = 10'(h);
    bus.vc = 10'(v);
    bus.btn_left  = bl;
    bus.btn_right = br;
    e.rgb = model_rgb(h, v);
    hv = 1'b0;
    if (h == 0 && v == 480) begin
      hit_ci_cap = m_ci;
      model_tick(hv);
    end
    if (c_rgb >= 0) e.rgb = 12'(c_rgb);
    e.hit   = hv;
    e.score = (c_score >= 0) ? 8'(c_score) : 8'(m_score);
    e.h     = 10'(h);
    e.v     = 10'(v);
    e.tag   = tag;
    sb.push_back(e);
    probe = 1'b1;
    @(posedge vgaclk);
    #1;
  endtask

  task automatic pix(input int h, input int v, input logic [7:0] tag, input int c_rgb);
    cyc(h, v, tag, c_rgb, -1);
  endtask

  task automatic frame(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(0, 480, T_MODEL, -1, -1);
      pix(m_bx, m_by, T_MODEL, -1);
      pix(m_bx + 23, m_by + 23, T_MODEL, -1);
      pix(m_bx + 24, m_by, T_MODEL, -1);
      pix(m_px, 450, T_MODEL, -1);
      pix(m_px + 31, 463, T_MODEL, -1);
      pix(m_px + 32, 450, T_MODEL, -1);
      pix((m_px > 0) ? m_px - 1 : 0, 447, T_MODEL, -1);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_t e;
      bus.hc = 10'd123;
      bus.vc = 10'd200;
      e = '{rgb: 12'h000, hit: 1'b0, score: 8'd0, h: 10'd123, v: 10'd200, tag: T_RESET};
      sb.push_back(e);
      probe = 1'b1;
      @(posedge vgaclk);
      #1;
    end
    rst = 1'b1;
    m_px = 304; m_bx = 225; m_by = 0; m_ci = 2; m_hci = 2; m_flash = 0; m_score = 0;
  endtask

  always @(posedge vgaclk) probe_d <= probe;

  always @(negedge vgaclk) begin : monitor
    exp_t        e;
    logic [11:0] act;
    if (probe_d) begin
      checks++;
      act = {bus.red, bus.green, bus.blue};
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty: output rgb=%h with no expectation queued", act);
      end else begin
        e = sb.pop_front();
        if ({act, bus.hit, bus.score} !== {e.rgb, e.hit, e.score}) begin
          errors++;
          $display("FAIL %s at hc=%0d vc=%0d: got rgb=%h hit=%b score=%0d, want rgb=%h hit=%b score=%0d",
                   tag_name(e.tag), e.h, e.v, act, bus.hit, bus.score, e.rgb, e.hit, e.score);
        end
      end
    end
  end

  initial begin
    rst = 1'b0;
    bus.hc = 10'd0; bus.vc = 10'd0; bus.btn_left = 1'b0; bus.btn_right = 1'b0;
    @(posedge vgaclk);
    #1;

    // Reset, then disturb the state and reset again mid-frame
    do_reset();
    br = 1'b1; frame(5); br = 1'b0;
    do_reset();
    pix(304, 448, T_RSTPIX, 12'hFFF);
    pix(225, 0,   T_RSTPIX, 12'h00F);
    pix(248, 23,  T_RSTPIX, 12'h00F);
    pix(249, 0,   T_RSTPIX, 12'h003);
    pix(700, 100, T_BLANK,  12'h000);
    pix(100, 500, T_BLANK,  12'h000);

    // Left clamp
    bl = 1'b1;
    frame(76);
    pix(0, 450,  T_LEFT, 12'hFFF);
    pix(32, 450, T_LEFT, 12'h003);
    frame(4);
    pix(0, 450,  T_LEFT, 12'hFFF);
    pix(31, 463, T_LEFT, 12'hFFF);
    pix(32, 450, T_LEFT, 12'h003);
    bl = 1'b0;

    // Right clamp
    do_reset();
    br = 1'b1;
    frame(80);
    pix(608, 450, T_RIGHT, 12'hFFF);
    pix(607, 450, T_RIGHT, 12'h003);
    pix(639, 463, T_RIGHT, 12'hFFF);
    br = 1'b0;

    // Both buttons: no move
    do_reset();
    bl = 1'b1; br = 1'b1;
    frame(10);
    pix(304, 450, T_BOTH, 12'hFFF);
    pix(303, 450, T_BOTH, 12'h003);
    pix(335, 450, T_BOTH, 12'hFFF);
    pix(336, 450, T_BOTH, 12'h003);
    bl = 1'b0; br = 1'b0;

    // Miss: block falls to the bottom and respawns
    do_reset();
    frame(239);
    cyc(225, 478, T_MISS, 12'h00F, 0);
    frame(1);
    cyc(225, 478, T_MISS, 12'h003, 0);
    frame(5);
    pix(100, 500, T_BLANK, 12'h000);

    // Hit: paddle moved to 248, block lands on it at tick 214
    do_reset();
    bl = 1'b1; frame(14); bl = 1'b0;
    frame(199);
    pix(248, 448, T_OVER, 12'h00F);
    pix(249, 448, T_OVER, 12'hFFF);
    frame(1);
    cyc(248, 450, T_HIT, 12'h00F, 1);
    frame(29);
    cyc(248, 450, T_HIT, 12'h00F, 1);
    frame(1);
    cyc(248, 450, T_HIT, 12'hFFF, 1);
    pix(700, 100, T_BLANK, 12'h000);

    probe = 1'b0;
    @(posedge vgaclk);
    #1;
    @(negedge vgaclk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
